// File: rtl/stream_counter_pkg.sv
// stream_counter_pkg: FSM state and mode encodings shared by the stream counter
package stream_counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT = 1'b1;
endpackage

// File: rtl/stream_counter_if.sv
// stream_counter_if: AXI-Stream handshake bundle
interface stream_counter_if #(parameter int DW = 32);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DW-1:0] tdata;
  modport master(output tvalid, tlast, tdata, input tready);
  modport slave(input tvalid, tdata, output tready);
endinterface

// File: rtl/stream_slice.sv
// stream_slice: one-stage AXI-Stream register slice with synchronous flush
module stream_slice #(parameter int W = 33) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = ~out_valid | out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data <= in_data;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: rtl/stream_counter.sv
// stream_counter: forwards cfg_cnt samples per packet, marking the last with tlast
module stream_counter import stream_counter_pkg::*; #(
  parameter int SDW = 32,
  parameter int SCW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctl_clr,
  input  logic             ctl_ena,
  input  logic [SCW-1:0]   cfg_cnt,
  input  logic             cfg_mode,
  stream_counter_if.slave  sti,
  stream_counter_if.master sto,
  output logic [SCW-1:0]   sts_cnt,
  output logic             sts_done
);
  state_t state;
  logic [SCW-1:0] cnt;
  logic s_rdy, load, last;
  logic [SDW:0] s_out;
  assign last = cnt == SCW'(1);
  // outside RUN every offered sample is swallowed so upstream never stalls
  assign sti.tready = ~ctl_clr & (state == RUN ? ctl_ena & s_rdy : 1'b1);
  assign load = sti.tvalid & sti.tready & (state == RUN);
  assign sts_cnt = cnt;
  assign {sto.tlast, sto.tdata} = s_out;
  stream_slice #(.W(SDW + 1)) u_slice (
    .clk,
    .rst,
    .flush(ctl_clr),
    .in_valid(load),
    .in_ready(s_rdy),
    .in_data({last, sti.tdata}),
    .out_valid(sto.tvalid),
    .out_ready(sto.tready),
    .out_data(s_out)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sts_done <= 1'b0;
    end else if (ctl_clr) begin
      state <= IDLE;
      cnt <= cfg_cnt;
      sts_done <= 1'b0;
    end else
      case (state)
        IDLE: if (ctl_ena) begin
          state <= cnt != '0 ? RUN : DONE;
          sts_done <= cnt == '0;
        end
        RUN: if (load) begin
          if (last && cfg_mode == MODE_ONESHOT) begin
            cnt <= '0;
            state <= DONE;
            sts_done <= 1'b1;
          end else if (last) cnt <= cfg_cnt;
          else if (cnt != '0) cnt <= cnt - SCW'(1);
        end
        default: ;
      endcase
endmodule

// File: tb/tb_stream_counter.sv
// tb_stream_counter: directed checks of counting, packetising, stalls, clear and reset
module tb_stream_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctl_clr = 1'b0;
  logic ctl_ena = 1'b0;
  logic cfg_mode = 1'b0;
  logic [31:0] cfg_cnt = '0;
  logic [31:0] sts_cnt;
  logic sts_done;
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [31:0] din;
  logic [32:0] exp_q[$];
  bit chk_hold = 0;
  always #5 clk = ~clk;
  stream_counter_if #(.DW(32)) sti();
  stream_counter_if #(.DW(32)) sto();
  stream_counter #(.SDW(32), .SCW(32)) dut (
    .clk,
    .rst,
    .ctl_clr,
    .ctl_ena,
    .cfg_cnt,
    .cfg_mode,
    .sti(sti),
    .sto(sto),
    .sts_cnt,
    .sts_done
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    bit ix, ox, hold;
    logic [32:0] pv;
    #1;
    ix = sti.tvalid && sti.tready;
    ox = sto.tvalid && sto.tready;
    hold = chk_hold && sto.tvalid && !sto.tready;
    pv = {sto.tlast, sto.tdata};
    if (ox) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", 64'(sto.tvalid), 64'd0);
      else check("out_data", 64'({sto.tlast, sto.tdata}), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (hold) check("stall_hold", 64'({sto.tvalid, sto.tlast, sto.tdata}), 64'({1'b1, pv}));
    if (ix) begin
      din++;
      sti.tdata = din;
    end
  endtask
  task automatic start(logic [31:0] n, logic m, logic [31:0] d0);
    cfg_cnt = n;
    cfg_mode = m;
    ctl_clr = 1'b1;
    ctl_ena = 1'b0;
    sti.tvalid = 1'b1;
    sto.tready = 1'b1;
    din = d0;
    sti.tdata = d0;
    n_out = 0;
    #1 check("clr_tready", 64'(sti.tready), 64'd0);
    cyc();
    ctl_clr = 1'b0;
    check("clr_cnt", 64'(sts_cnt), 64'(n));
    ctl_ena = 1'b1;
    sti.tvalid = 1'b0;
    cyc();
    sti.tvalid = 1'b1;
  endtask
  initial begin
    sti.tvalid = 1'b0;
    sti.tdata = 32'h55;
    sti.tlast = 1'b0;
    sto.tready = 1'b1;
    din = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(sto.tvalid), 64'd0);
    check("rst_tlast", 64'(sto.tlast), 64'd0);
    check("rst_tdata", 64'(sto.tdata), 64'd0);
    check("rst_cnt", 64'(sts_cnt), 64'd0);
    check("rst_done", 64'(sts_done), 64'd0);
    rst = 1'b0;
    sti.tvalid = 1'b1;
    repeat (3) cyc();
    check("idle_rdy", 64'(sti.tready), 64'd1);
    check("idle_done", 64'(sts_done), 64'd0);
    check("idle_nout", 64'(n_out), 64'd0);
    // one-shot packet of four
    start(32'd4, 1'b0, 32'hA0);
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'hA0 + 32'(i)});
    for (int i = 0; i < 4; i++) begin
      check("t1_cnt", 64'(sts_cnt), 64'(4 - i));
      cyc();
    end
    check("t1_done", 64'(sts_done), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t1_done_rdy", 64'(sti.tready), 64'd1);
    end
    check("t1_nout", 64'(n_out), 64'd4);
    // continuous packets of three
    start(32'd3, 1'b1, 32'hB0);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({i % 3 == 2, 32'hB0 + 32'(i)});
      check("t2_cnt", 64'(sts_cnt), 64'(3 - i % 3));
      cyc();
    end
    sti.tvalid = 1'b0;
    repeat (2) cyc();
    check("t2_nout", 64'(n_out), 64'd9);
    check("t2_done", 64'(sts_done), 64'd0);
    // output backpressure 1010
    start(32'd4, 1'b0, 32'hC0);
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'hC0 + 32'(i)});
    chk_hold = 1;
    for (int i = 0; i < 16; i++) begin
      sto.tready = (i % 2 == 0);
      cyc();
    end
    chk_hold = 0;
    sto.tready = 1'b1;
    repeat (2) cyc();
    check("t3_nout", 64'(n_out), 64'd4);
    check("t3_done", 64'(sts_done), 64'd1);
    // enable pause mid-packet
    start(32'd5, 1'b0, 32'hD0);
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 32'hD0 + 32'(i)});
    repeat (2) cyc();
    ctl_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_pause_rdy", 64'(sti.tready), 64'd0);
      check("t4_pause_cnt", 64'(sts_cnt), 64'd3);
      cyc();
    end
    ctl_ena = 1'b1;
    for (int i = 0; i < 12; i++) if (!sts_done) cyc();
    check("t4_done", 64'(sts_done), 64'd1);
    cyc();
    check("t4_nout", 64'(n_out), 64'd5);
    // clear with a sample pending
    start(32'd6, 1'b0, 32'hE0);
    sto.tready = 1'b0;
    cyc();
    check("t5_pending", 64'(sto.tvalid), 64'd1);
    ctl_clr = 1'b1;
    ctl_ena = 1'b0;
    #1 check("t5_clr_rdy", 64'(sti.tready), 64'd0);
    cyc();
    ctl_clr = 1'b0;
    check("t5_tvalid", 64'(sto.tvalid), 64'd0);
    check("t5_cnt", 64'(sts_cnt), 64'd6);
    check("t5_done", 64'(sts_done), 64'd0);
    sto.tready = 1'b1;
    repeat (2) cyc();
    check("t5_idle_cnt", 64'(sts_cnt), 64'd6);
    check("t5_idle_rdy", 64'(sti.tready), 64'd1);
    check("t5_nout", 64'(n_out), 64'd0);
    // asynchronous reset with a sample pending
    start(32'd6, 1'b0, 32'hF0);
    sto.tready = 1'b0;
    cyc();
    check("t6_pending", 64'(sto.tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_tvalid", 64'(sto.tvalid), 64'd0);
    check("t6_tlast", 64'(sto.tlast), 64'd0);
    check("t6_tdata", 64'(sto.tdata), 64'd0);
    check("t6_cnt", 64'(sts_cnt), 64'd0);
    check("t6_done", 64'(sts_done), 64'd0);
    ctl_ena = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    sto.tready = 1'b1;
    repeat (2) cyc();
    check("t6_idle_done", 64'(sts_done), 64'd0);
    check("t6_idle_cnt", 64'(sts_cnt), 64'd0);
    check("t6_nout", 64'(n_out), 64'd0);
    // zero count goes straight to DONE
    start(32'd0, 1'b0, 32'h10);
    check("t7_done", 64'(sts_done), 64'd1);
    check("t7_tvalid", 64'(sto.tvalid), 64'd0);
    check("t7_rdy", 64'(sti.tready), 64'd1);
    repeat (3) cyc();
    check("t7_nout", 64'(n_out), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stream_counter.md
STREAM_COUNTER -- requirements
Module: stream_counter

Interface
REQ-001 SHALL have parameter SDW, default 32, sample data width in bits.
REQ-002 SHALL have parameter SCW, default 32, sample counter width in bits.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ctl_clr  input  1  load counter from cfg_cnt, return to IDLE, flush output.
REQ-006 SHALL have port ctl_ena  input  1  start/continue counting; low in RUN stalls input.
REQ-007 SHALL have port cfg_cnt  input  SCW  samples per packet.
REQ-008 SHALL have port cfg_mode  input  1  0 = one-shot (stop in DONE), 1 = continuous (reload, emit packets).
REQ-009 SHALL have ports sti_tready output 1, sti_tvalid input 1, sti_tdata input SDW: AXI-Stream input.
REQ-010 SHALL have ports sto_tready input 1, sto_tvalid output 1, sto_tlast output 1, sto_tdata output SDW: AXI-Stream output.
REQ-011 SHALL have port sts_cnt  output  SCW  current remaining count.
REQ-012 SHALL have port sts_done  output  1  high while in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 ctl_clr SHALL have highest priority: cnt <= cfg_cnt, state <= IDLE, sto_tvalid <= 0 (pending sample dropped); sti_tready SHALL be 0 in any cycle with ctl_clr=1.
REQ-015 IDLE: ctl_ena=1 and cnt!=0 -> RUN; ctl_ena=1 and cnt==0 -> DONE; otherwise stay.
REQ-016 IDLE and DONE: sti_tready SHALL be 1 (ctl_clr=0); accepted samples discarded, never reach output.
REQ-017 RUN: sti_tready SHALL equal ctl_ena & (~sto_tvalid | sto_tready); no input transfer while ctl_ena=0.
REQ-018 RUN: each input transfer SHALL load output register (data, tlast) and decrement cnt by 1; latency input-to-output exactly 1 cycle; full throughput of one sample per cycle under continuous tready.
REQ-019 sto_tlast SHALL be 1 on the sample accepted while cnt==1, else 0.
REQ-020 On the transfer with cnt==1: cfg_mode=0 -> cnt <= 0, state <= DONE; cfg_mode=1 -> cnt <= cfg_cnt (value that cycle), stay RUN.
REQ-021 cnt SHALL never wrap below 0; cfg_cnt sampled only at ctl_clr and at REQ-020 reload.
REQ-022 Output register SHALL hold data/tlast stable while sto_tvalid=1 and sto_tready=0; sto_tvalid cleared on output transfer with no new input transfer.
REQ-023 Sample already in output register at entry to DONE SHALL still be delivered.
REQ-024 sts_cnt SHALL equal cnt; sts_done SHALL be 1 exactly when state==DONE.

Reset
REQ-025 rst SHALL force: state IDLE, cnt 0, sto_tvalid 0, sto_tlast 0, sto_tdata 0, sts_done 0; mid-packet reset discards the pending sample.
REQ-026 After rst release, block SHALL stay in IDLE until ctl_clr loads a nonzero count and ctl_ena is asserted.

Structure
REQ-027 Package stream_counter_pkg SHALL hold state enum typedef and cfg_mode constants (MODE_ONESHOT=0, MODE_CONT=1).
REQ-028 Output register SHALL be a sub-module stream_slice (one-stage AXI-Stream register slice, payload width SDW+1, with synchronous flush input).

Verification
REQ-029 cfg_cnt=4, mode 0, clr then ena, tvalid continuous, tready=1 -> 4 outputs data D0..D3, tlast only on D3, sts_done=1 one cycle after D3 accepted, later inputs discarded.
REQ-030 cfg_cnt=3, mode 1, 9 inputs -> tlast on samples 3, 6, 9; sts_cnt sequence 3,2,1,3,2,1,3,2,1.
REQ-031 cfg_cnt=4, sto_tready toggling 1010 -> no sample lost or duplicated, data stable while stalled, tlast on 4th.
REQ-032 cfg_cnt=5, drop ctl_ena after 2 transfers for 3 cycles -> sti_tready=0 those cycles, sts_cnt holds 3, resumes to completion.
REQ-033 ctl_clr and rst each asserted mid-packet with sample pending -> sto_tvalid 0 next cycle (rst: immediately), state IDLE, sts_cnt = cfg_cnt (clr) or 0 (rst).
REQ-034 cfg_cnt=0, clr then ena -> DONE next cycle, no output sample, sti_tready=1.
